// File: rtl/count_sched.sv
// count_sched: round-robin scheduler that shares one WIDTH-bit up-counter among NREQ requesters.
//
// Each requester raises Req[i] with a target count in Len[i*WIDTH +: WIDTH].
// The winner is granted, the shared counter is cleared for one cycle, then
// enabled until Count matches the latched length, and Done[owner] pulses once.
//
// Ports:
//   Clock    in   rising-edge system clock
//   Resetn   in   asynchronous active-low reset
//   Req      in   [NREQ]        request levels, held until Done
//   Len      in   [NREQ*WIDTH]  packed target counts
//   Count    in   [WIDTH]       current value of the shared counter
//   CntEn    out               counter enable
//   CntClrn  out               counter synchronous clear, active low
//   Grant    out  [NREQ]        one-hot owner, zero when idle
//   GrantId  out  [IDW]         binary owner index, zero when idle
//   Done     out  [NREQ]        one-cycle completion pulse to the owner
//   Busy     out               high outside IDLE
//
// Build option: define COUNT_SCHED_ABORT_EN to abandon a job when the owner
// drops Req during CLEAR or RUN (no Done pulse, pointer still advances).
module count_sched #(
   parameter int WIDTH = 8,
   parameter int NREQ  = 2,
   parameter int IDW   = 3
) (
   input  logic                  Clock,
   input  logic                  Resetn,
   input  logic [NREQ-1:0]       Req,
   input  logic [NREQ*WIDTH-1:0] Len,
   input  logic [WIDTH-1:0]      Count,
   output logic                  CntEn,
   output logic                  CntClrn,
   output logic [NREQ-1:0]       Grant,
   output logic [IDW-1:0]        GrantId,
   output logic [NREQ-1:0]       Done,
   output logic                  Busy
);
   typedef enum logic [1:0] {IDLE, CLEAR, RUN, DONE} state_t;
   state_t state, state_nxt;
   logic [IDW-1:0] owner, rr, sel, rr_nxt;
   logic [WIDTH-1:0] len_q, sel_len;
   logic [NREQ-1:0] owner_oh;
   logic hit, abort;
   assign owner_oh = NREQ'(1) << owner;
   assign hit = Count == len_q;
   assign rr_nxt = owner == IDW'(NREQ - 1) ? '0 : owner + 1'b1;
`ifdef COUNT_SCHED_ABORT_EN
   assign abort = (state == CLEAR || state == RUN) && !(|(Req & owner_oh));
`else
   assign abort = 1'b0;
`endif
   // Walk downward from the farthest candidate so the nearest set bit at or
   // after the pointer (with wrap) is the one left in sel.
   always_comb begin
      int idx;
      idx = 0;
      sel = rr;
      sel_len = '0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         idx = int'(rr) + k;
         if (idx >= NREQ) idx = idx - NREQ;
         if (Req[idx]) begin
            sel = IDW'(idx);
            sel_len = WIDTH'(Len >> (idx * WIDTH));
         end
      end
   end
   always_comb begin
      state_nxt = state;
      state_nxt = abort ? IDLE :
                  state == IDLE  ? (|Req ? CLEAR : IDLE) :
                  state == CLEAR ? RUN :
                  state == RUN   ? (hit ? DONE : RUN) : IDLE;
      CntEn = state == RUN && !hit && !abort;
      CntClrn = state != CLEAR;
      Busy = state != IDLE;
      Grant = Busy ? owner_oh : '0;
      GrantId = Busy ? owner : '0;
      Done = state == DONE ? owner_oh : '0;
   end
   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         state <= IDLE;
         rr <= '0;
         len_q <= '0;
         owner <= '0;
      end else begin
         state <= state_nxt;
         if (state == IDLE && |Req) begin
            owner <= sel;
            len_q <= sel_len;
         end
         if (state == DONE || abort) rr <= rr_nxt;
      end
   end
endmodule

// File: tb/tb_count_sched.sv
// tb_count_sched: randomized and directed bench for count_sched against a job-level timing model.
module tb_count_sched;
   localparam int WIDTH = 8;
   localparam int NREQ  = 2;
   localparam int IDW   = 3;
   logic                  Clock = 1'b0;
   logic                  Resetn = 1'b0;
   logic [NREQ-1:0]       Req = '0;
   logic [NREQ*WIDTH-1:0] Len = '0;
   logic [WIDTH-1:0]      Count;
   logic                  CntEn, CntClrn, Busy;
   logic [NREQ-1:0]       Grant, Done;
   logic [IDW-1:0]        GrantId;

   count_sched #(.WIDTH(WIDTH), .NREQ(NREQ), .IDW(IDW)) dut (
      .Clock(Clock), .Resetn(Resetn), .Req(Req), .Len(Len), .Count(Count),
      .CntEn(CntEn), .CntClrn(CntClrn), .Grant(Grant), .GrantId(GrantId),
      .Done(Done), .Busy(Busy)
   );

   always #5 Clock = ~Clock;

   // the shared external counter
   always @(posedge Clock or negedge Resetn) begin
      if (!Resetn) Count <= '0;
      else if (!CntClrn) Count <= '0;
      else if (CntEn) Count <= Count + 1'b1;
   end

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;
   int free_at = 0;
   int t = 0, o = 0, l = 0, done_at = 0, en_cnt = 0, ptr = 0, t0 = 0;
   bit active = 0;
   bit rnd = 0;
   int again [NREQ];
   logic [NREQ-1:0] done_q [$];
   int done_cyc [$];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic int rand_len();
      return ($urandom_range(0, 39) == 0) ? int'($urandom_range(10, 60)) : int'($urandom_range(0, 9));
   endfunction

   // One job = owner o granted at IDLE cycle t: CLEAR at t+1, counting from
   // t+2 for l cycles, Done at t+3+l, then one IDLE cycle before the next job.
   task automatic tick();
      bit act;
      logic [NREQ-1:0] oh;
      @(negedge Clock);
      cyc++;
      act = active && cyc > t;
      oh = '0;
      if (act) oh[o] = 1'b1;
      check("grant", Grant, oh);
      check("grant_id", GrantId, act ? o : 0);
      check("busy", Busy, act);
      check("cnt_clrn", CntClrn, !(act && cyc == t + 1));
      check("cnt_en", CntEn, act && cyc >= t + 2 && cyc <= t + 1 + l);
      check("done", Done, (act && cyc == done_at) ? oh : '0);
      if (CntEn) en_cnt++;
      if (Done != 0) begin
         done_q.push_back(Done);
         done_cyc.push_back(cyc);
      end
      if (act && cyc == done_at) begin
         check("count_at_done", Count, l);
         check("en_cycles", en_cnt, l);
         active = 0;
         free_at = cyc + 1;
         ptr = (o + 1) % NREQ;
         if (rnd && $urandom_range(0, 2) == 0) Len[o*WIDTH +: WIDTH] = WIDTH'(rand_len());
         else if (again[o] > 0) again[o]--;
         else Req[o] = 1'b0;
      end
   endtask

   task automatic arbitrate();
      int pick;
      pick = -1;
`ifdef COUNT_SCHED_ABORT_EN
      if (active && cyc > t && cyc <= t + 2 + l && !Req[o]) begin
         active = 0;
         free_at = cyc + 1;
         ptr = (o + 1) % NREQ;
      end
`endif
      if (!active && cyc >= free_at && Req != 0) begin
         for (int k = 0; k < NREQ; k++)
            if (pick < 0 && Req[(ptr + k) % NREQ]) pick = (ptr + k) % NREQ;
         active = 1;
         t = cyc;
         o = pick;
         l = int'(Len[pick*WIDTH +: WIDTH]);
         done_at = t + 3 + l;
         en_cnt = 0;
      end
   endtask

   task automatic stimulate();
      for (int i = 0; i < NREQ; i++)
         if (!Req[i] && $urandom_range(0, 3) == 0) begin
            Req[i] = 1'b1;
            Len[i*WIDTH +: WIDTH] = WIDTH'(rand_len());
         end
      if (active && $urandom_range(0, 1) == 0) Len[o*WIDTH +: WIDTH] = WIDTH'($urandom_range(0, 255));
   endtask

   task automatic step();
      tick();
      if (rnd) stimulate();
      arbitrate();
   endtask

   task automatic run_idle(input int max);
      int i;
      i = 0;
      while ((active || Req != 0) && i < max) begin
         step();
         i++;
      end
      check("drain_bound", active || Req != 0, 0);
      step();
   endtask

   task automatic reset_dut();
      Resetn = 1'b0;
      Req = '0;
      active = 0;
      ptr = 0;
      for (int i = 0; i < NREQ; i++) again[i] = 0;
      repeat (2) @(posedge Clock);
      @(negedge Clock);
      check("rst_grant", Grant, 0);
      check("rst_grant_id", GrantId, 0);
      check("rst_done", Done, 0);
      check("rst_busy", Busy, 0);
      check("rst_cnt_en", CntEn, 0);
      check("rst_cnt_clrn", CntClrn, 1);
      Resetn = 1'b1;
      cyc = 0;
      free_at = 0;
      done_q.delete();
      done_cyc.delete();
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      // single job, Len=5
      reset_dut();
      Len = '0;
      Len[0 +: WIDTH] = 8'd5;
      Req = 2'b01;
      arbitrate();
      t0 = cyc;
      run_idle(50);
      check("a_done_count", done_q.size(), 1);
      check("a_done_lat", done_cyc.size() > 0 ? done_cyc[0] - t0 : -1, 8);
      check("a_count_hold", Count, 5);
      // simultaneous requests, requester 0 asks twice
      reset_dut();
      Len = {8'd2, 8'd3};
      Req = 2'b11;
      again[0] = 1;
      arbitrate();
      t0 = cyc;
      run_idle(80);
      check("b_jobs", done_q.size(), 3);
      if (done_q.size() == 3) begin
         check("b_first", done_q[0], 2'b01);
         check("b_second", done_q[1], 2'b10);
         check("b_third", done_q[2], 2'b01);
         check("b_lat0", done_cyc[0] - t0, 6);
         check("b_lat1", done_cyc[1] - t0, 12);
         check("b_lat2", done_cyc[2] - t0, 19);
      end
      // Len=0
      done_q.delete();
      done_cyc.delete();
      Len[0 +: WIDTH] = 8'd0;
      Req = 2'b01;
      arbitrate();
      t0 = cyc;
      run_idle(20);
      check("c_done_lat", done_cyc.size() > 0 ? done_cyc[0] - t0 : -1, 3);
      // full-scale length, no wrap
      done_q.delete();
      done_cyc.delete();
      Len[0 +: WIDTH] = 8'd255;
      Req = 2'b01;
      arbitrate();
      t0 = cyc;
      run_idle(300);
      check("d_done_lat", done_cyc.size() > 0 ? done_cyc[0] - t0 : -1, 258);
      check("d_count", Count, 255);
      // asynchronous reset mid-RUN
      Len[0 +: WIDTH] = 8'd10;
      Req = 2'b01;
      arbitrate();
      for (int i = 0; i < 20 && Count != 4; i++) step();
      check("e_count4", Count, 4);
      #2 Resetn = 1'b0;
      #1;
      check("e_async_grant", Grant, 0);
      check("e_async_busy", Busy, 0);
      check("e_async_en", CntEn, 0);
      check("e_async_clrn", CntClrn, 1);
      check("e_async_id", GrantId, 0);
      reset_dut();
      Len[WIDTH +: WIDTH] = 8'd4;
      Req = 2'b10;
      arbitrate();
      run_idle(30);
      check("e_owner", done_q.size() > 0 ? done_q[0] : '0, 2'b10);
      // owner drops Req mid-RUN
      reset_dut();
      Len[0 +: WIDTH] = 8'd10;
      Req = 2'b01;
      arbitrate();
      t0 = cyc;
      for (int i = 0; i < 20 && Count != 3; i++) step();
      check("f_count3", Count, 3);
      Req[0] = 1'b0;
      arbitrate();
      run_idle(30);
`ifdef COUNT_SCHED_ABORT_EN
      check("f_no_done", done_q.size(), 0);
`else
      check("f_done", done_q.size(), 1);
      check("f_done_lat", done_cyc.size() > 0 ? done_cyc[0] - t0 : -1, 13);
`endif
      done_q.delete();
      done_cyc.delete();
      Len = {8'd1, 8'd1};
      Req = 2'b11;
      arbitrate();
      run_idle(30);
      check("f_ptr_next", done_q.size() > 0 ? done_q[0] : '0, 2'b10);
      // randomized traffic
      reset_dut();
      rnd = 1;
      repeat (2500) step();
      rnd = 0;
      run_idle(1000);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
